// File: rtl/sipo_rx.sv
// sipo_rx: SCK-sampled serial-to-parallel receiver, MSB first, oversampled on CLK.
// Optional SIPO_RX_OVERRUN_EN adds a DATA_ACK handshake and a sticky OVERRUN flag.
module sipo_rx #(
  parameter int D_Pack = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCK,
  input  logic              SER_IN,
  input  logic              ENABLE,
  input  logic              C_PH,
`ifdef SIPO_RX_OVERRUN_EN
  input  logic              DATA_ACK,
  output logic              OVERRUN,
`endif
  output logic [D_Pack-1:0] DATA_OUT,
  output logic              DATA_VALID,
  output logic              ABORT
);
  localparam int CW = $clog2(D_Pack) + 1;
  localparam logic [CW-1:0] LAST = CW'(D_Pack - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [1:0] sck_q, sck_d, ser_q, ser_d, en_q, en_d;
  logic sck_prev_q, sck_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [D_Pack-1:0] sr_q, sr_d, data_q, data_d;
  logic valid_q, valid_d, abort_q, abort_d, overrun_q, overrun_d;
  logic smp, word_done;
  always_comb begin
    sck_d = {sck_q[0], SCK};
    ser_d = {ser_q[0], SER_IN};
    en_d = {en_q[0], ENABLE};
    sck_prev_d = sck_q[1];
    smp = C_PH ? (sck_prev_q & ~sck_q[1]) : (~sck_prev_q & sck_q[1]);
    state_d = state_q;
    cnt_d = cnt_q;
    sr_d = sr_q;
    data_d = data_q;
    abort_d = 1'b0;
    overrun_d = overrun_q;
    word_done = 1'b0;
    if (state_q == IDLE) begin
      if (!en_q[1]) begin
        state_d = SHIFT;
        cnt_d = '0;
      end
    end else if (en_q[1]) begin
      // frame end beats a coincident sampling edge
      state_d = IDLE;
      abort_d = cnt_q != '0;
      cnt_d = '0;
    end else if (smp) begin
      sr_d = {sr_q[D_Pack-2:0], ser_q[1]};
      word_done = cnt_q == LAST;
      cnt_d = word_done ? '0 : cnt_q + 1'b1;
    end
`ifdef SIPO_RX_OVERRUN_EN
    valid_d = valid_q & ~DATA_ACK;
    if (word_done) begin
      if (valid_q && !DATA_ACK) overrun_d = 1'b1;
      else begin
        data_d = sr_d;
        valid_d = 1'b1;
      end
    end
`else
    valid_d = word_done;
    data_d = word_done ? sr_d : data_q;
`endif
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sck_q <= 2'b00;
      ser_q <= 2'b00;
      en_q <= 2'b11;
      sck_prev_q <= 1'b0;
      cnt_q <= '0;
      sr_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sck_q <= sck_d;
      ser_q <= ser_d;
      en_q <= en_d;
      sck_prev_q <= sck_prev_d;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      data_q <= data_d;
      valid_q <= valid_d;
      abort_q <= abort_d;
      overrun_q <= overrun_d;
    end
  end
  assign DATA_OUT = data_q;
  assign DATA_VALID = valid_q;
  assign ABORT = abort_q;
`ifdef SIPO_RX_OVERRUN_EN
  assign OVERRUN = overrun_q;
`else
  logic unused_ok;
  assign unused_ok = overrun_q;
`endif
endmodule
